// File: rtl/control_sequencer_pkg.sv
// Shared processor package: opcode map, sequencer state encoding, strobe
// bit positions and the strobe bundle produced by the decoder.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_WB      = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  // Opcodes (instr[31:26]); 0x00-0x0F is the ALU class.
  localparam logic [5:0] OP_LOAD  = 6'h10;
  localparam logic [5:0] OP_LDSR  = 6'h12;
  localparam logic [5:0] OP_TXS   = 6'h20;
  localparam logic [5:0] OP_TSX   = 6'h21;
  localparam logic [5:0] OP_TAY   = 6'h22;
  localparam logic [5:0] OP_TYA   = 6'h23;
  localparam logic [5:0] OP_TAX   = 6'h24;
  localparam logic [5:0] OP_TXA   = 6'h25;
  localparam logic [5:0] OP_TXAUX = 6'h26;
  localparam logic [5:0] OP_TAUXX = 6'h27;
  localparam logic [5:0] OP_TAXBR = 6'h28;
  localparam logic [5:0] OP_CLRBR = 6'h29;
  localparam logic [5:0] OP_INPUT = 6'h30;
  localparam logic [5:0] OP_CPF   = 6'h31;
  localparam logic [5:0] OP_PFIN  = 6'h32;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  // ALUWriteSignals bit positions ([5] reserved, always 0)
  localparam int AW_ACC    = 0;
  localparam int AW_X      = 1;
  localparam int AW_Y      = 2;
  localparam int AW_SP     = 3;
  localparam int AW_ALU_RD = 4;

  // TransferSignals bit positions
  localparam int TR_ACC_RD = 0;
  localparam int TR_ACC_WR = 1;
  localparam int TR_X_RD   = 2;
  localparam int TR_X_WR   = 3;
  localparam int TR_Y_RD   = 4;
  localparam int TR_Y_WR   = 5;
  localparam int TR_SP_RD  = 6;
  localparam int TR_SP_WR  = 7;
  localparam int TR_BR_WR  = 8;

  // AuxSignals bit positions
  localparam int AUX_WR = 0;
  localparam int AUX_RD = 1;

  typedef struct packed {
    logic [5:0] alu_wr;
    logic [8:0] xfer;
    logic [1:0] aux;
    logic       sr_wr;
    logic       mem_rd;
    logic       input_sig;
    logic       cff;
    logic       pfin;
  } strobe_t;

  function automatic logic is_alu_op(input logic [5:0] op);
    return op[5:4] == 2'b00;
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LOAD) || (op == OP_LDSR);
  endfunction

endpackage

// File: rtl/control_sequencer_strobe_decoder.sv
// strobe_decoder: purely combinational opcode -> write-strobe decode.
//   opcode  in  6   instr[31:26]
//   dest    in  2   ALU destination (instr[25:24])
//   wb      in  1   sequencer is in WRITEBACK; strobes are zero otherwise
//   strobes out     strobe bundle (strobe_t)
//   legal   out 1   opcode is a defined instruction (independent of wb)
module strobe_decoder
  import control_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [1:0] dest,
  input  logic       wb,
  output strobe_t    strobes,
  output logic       legal
);

  strobe_t s;

  always_comb begin
    s     = '0;
    legal = 1'b1;
    if (is_alu_op(opcode)) begin
      s.alu_wr[AW_ALU_RD]       = 1'b1;
      s.alu_wr[{1'b0, dest}]    = 1'b1;
      s.sr_wr                   = 1'b1;
    end else begin
      case (opcode)
        OP_LOAD:  begin s.mem_rd = 1'b1; s.alu_wr[AW_ACC] = 1'b1; end
        OP_LDSR:  begin s.mem_rd = 1'b1; s.sr_wr = 1'b1; end
        OP_TXS:   begin s.xfer[TR_X_RD]   = 1'b1; s.xfer[TR_SP_WR]  = 1'b1; end
        OP_TSX:   begin s.xfer[TR_SP_RD]  = 1'b1; s.xfer[TR_X_WR]   = 1'b1; end
        OP_TAY:   begin s.xfer[TR_ACC_RD] = 1'b1; s.xfer[TR_Y_WR]   = 1'b1; end
        OP_TYA:   begin s.xfer[TR_Y_RD]   = 1'b1; s.xfer[TR_ACC_WR] = 1'b1; end
        OP_TAX:   begin s.xfer[TR_ACC_RD] = 1'b1; s.xfer[TR_X_WR]   = 1'b1; end
        OP_TXA:   begin s.xfer[TR_X_RD]   = 1'b1; s.xfer[TR_ACC_WR] = 1'b1; end
        OP_TXAUX: begin s.aux[AUX_WR] = 1'b1; s.xfer[TR_X_RD]  = 1'b1; end
        OP_TAUXX: begin s.aux[AUX_RD] = 1'b1; s.xfer[TR_X_WR]  = 1'b1; end
        OP_TAXBR: begin s.aux[AUX_RD] = 1'b1; s.xfer[TR_BR_WR] = 1'b1; end
        OP_CLRBR: s.xfer[TR_BR_WR] = 1'b1;
        OP_INPUT: begin s.input_sig = 1'b1; s.alu_wr[AW_Y] = 1'b1; end
        OP_CPF:   begin s.cff = 1'b1; s.alu_wr[AW_Y] = 1'b1; end
        OP_PFIN:  begin s.pfin = 1'b1; s.sr_wr = 1'b1; end
        OP_HLT:   s = '0;  // legal, but never reaches WRITEBACK
        default:  legal = 1'b0;
      endcase
    end
  end

  assign strobes = wb ? s : '0;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: instruction fetch/decode/execute sequencer.
//   clock, reset(async, active low)
//   mem_req/mem_addr/mem_ready/mem_rdata : fetch and data-load handshake
//   ALUWriteSignals, TransferSignals, AuxSignals, SRWrite, MemDataRead,
//   InputSignal, CFFSignal, procFinishSignal : one-cycle WRITEBACK strobes
//   alu_op : ALU function of the current ALU-class instruction
//   pc, halted, illegal (sticky until reset)
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [5:0]  ALUWriteSignals,
  output logic [8:0]  TransferSignals,
  output logic [1:0]  AuxSignals,
  output logic        SRWrite,
  output logic        MemDataRead,
  output logic        InputSignal,
  output logic        CFFSignal,
  output logic        procFinishSignal,
  output logic [3:0]  alu_op,
  output logic [31:0] pc,
  output logic        halted,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, instr_q;
  logic        illegal_q;
  logic        run_q;      // low in the reset cycle so mem_req stays off until the first edge
  logic [5:0]  opcode;
  logic [1:0]  dest;
  logic        wb;
  logic        op_legal;
  strobe_t     strb;
  logic        unused_instr;

  assign opcode       = instr_q[31:26];
  assign dest         = instr_q[25:24];
  assign wb           = (state_q == ST_WB);
  assign unused_instr = ^instr_q[23:16];

  strobe_decoder u_dec (
    .opcode  (opcode),
    .dest    (dest),
    .wb      (wb),
    .strobes (strb),
    .legal   (op_legal)
  );

  always_comb begin
    state_d  = state_q;
    mem_req  = 1'b0;
    mem_addr = pc_q;
    case (state_q)
      ST_FETCH: begin
        mem_req = run_q;
        if (run_q && mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if (opcode == OP_HLT)     state_d = ST_HALT;
        else if (is_mem_op(opcode)) state_d = ST_MEMWAIT;
        else                      state_d = ST_WB;
      end
      ST_MEMWAIT: begin
        mem_req  = 1'b1;
        mem_addr = {16'b0, instr_q[15:0]};
        if (mem_ready) state_d = ST_WB;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_q == ST_FETCH && run_q && mem_ready) instr_q <= mem_rdata;
      // pc is only written here so it holds its value in every other state
      if (wb) begin
        pc_q <= pc_q + 32'd1;
        if (!op_legal) illegal_q <= 1'b1;
      end
    end
  end

  assign ALUWriteSignals  = strb.alu_wr;
  assign TransferSignals  = strb.xfer;
  assign AuxSignals       = strb.aux;
  assign SRWrite          = strb.sr_wr;
  assign MemDataRead      = strb.mem_rd | (state_q == ST_MEMWAIT);
  assign InputSignal      = strb.input_sig;
  assign CFFSignal        = strb.cff;
  assign procFinishSignal = strb.pfin;

  assign alu_op  = (is_alu_op(opcode) &&
                    (state_q inside {ST_DECODE, ST_EXEC, ST_MEMWAIT, ST_WB}))
                   ? instr_q[29:26] : 4'd0;
  assign pc      = pc_q;
  assign halted  = (state_q == ST_HALT);
  assign illegal = illegal_q;

endmodule
